// File: rtl/map_port_arbiter_if.sv
// map_port_arbiter_if: video/aux request, map port and status signals of the map port arbiter
interface map_port_arbiter_if;
   logic        vid_req;
   logic [9:0]  vid_row;
   logic [9:0]  vid_col;
   logic [1:0]  vid_pixel;
   logic        vid_pixel_valid;
   logic        aux_req;
   logic [9:0]  aux_row;
   logic [9:0]  aux_col;
   logic        aux_ack;
   logic [1:0]  aux_pixel;
   logic [9:0]  map_row;
   logic [9:0]  map_col;
   logic [1:0]  map_pixel;
   logic [15:0] vid_drop_cnt;
   logic [15:0] aux_grant_cnt;
   modport slave (
      input  vid_req, vid_row, vid_col, aux_req, aux_row, aux_col, map_pixel,
      output vid_pixel, vid_pixel_valid, aux_ack, aux_pixel, map_row, map_col,
             vid_drop_cnt, aux_grant_cnt
   );
   modport master (
      output vid_req, vid_row, vid_col, aux_req, aux_row, aux_col, map_pixel,
      input  vid_pixel, vid_pixel_valid, aux_ack, aux_pixel, map_row, map_col,
             vid_drop_cnt, aux_grant_cnt
   );
endinterface

// File: rtl/map_port_arbiter.sv
// map_port_arbiter: shares the map read port between video (priority) and an aux requester,
// with a starvation guard and a latency-matched tag pipe routing return data.
module map_port_arbiter #(
   parameter int MAP_LAT      = 1,
   parameter int STARVE_LIMIT = 64
) (
   input logic              clk,
   input logic              reset,
   map_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, PENDING, INFLIGHT, DONE} state_t;
   localparam logic [1:0] T_NONE = 2'd0;
   localparam logic [1:0] T_VID  = 2'd1;
   localparam logic [1:0] T_AUX  = 2'd2;
   state_t                 state_q, state_d;
   logic [7:0]             wait_q, wait_d;
   logic [MAP_LAT:0][1:0]  tag_q, tag_d;
   logic [9:0]             map_row_q, map_row_d, map_col_q, map_col_d;
   logic [1:0]             vid_pixel_q, vid_pixel_d, aux_pixel_q, aux_pixel_d;
   logic                   vid_valid_q, vid_valid_d, aux_ack_q, aux_ack_d;
   logic [15:0]            drop_q, drop_d, grant_q, grant_d;
   logic                   issue_aux, issue_vid;
   logic [1:0]             ret;
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      issue_aux = 1'b0;
      ret       = tag_q[MAP_LAT];
      unique case (state_q)
         IDLE:     if (bus.aux_req) begin
                      state_d = PENDING;
                      wait_d  = '0;
                   end
         PENDING:  if (!bus.aux_req) state_d = IDLE;
                   else if (!bus.vid_req || wait_q == 8'(STARVE_LIMIT - 1)) begin
                      issue_aux = 1'b1;
                      state_d   = INFLIGHT;
                      wait_d    = '0;
                   end else wait_d = wait_q + 8'd1;
         INFLIGHT: if (ret == T_AUX) state_d = DONE;
         DONE:     state_d = IDLE;
      endcase
      issue_vid   = bus.vid_req && !issue_aux;
      map_row_d   = issue_aux ? bus.aux_row : issue_vid ? bus.vid_row : map_row_q;
      map_col_d   = issue_aux ? bus.aux_col : issue_vid ? bus.vid_col : map_col_q;
      tag_d       = {tag_q[MAP_LAT-1:0], issue_aux ? T_AUX : issue_vid ? T_VID : T_NONE};
      vid_valid_d = ret == T_VID;
      vid_pixel_d = vid_valid_d ? bus.map_pixel : vid_pixel_q;
      aux_ack_d   = ret == T_AUX;
      aux_pixel_d = aux_ack_d ? bus.map_pixel : aux_pixel_q;
      grant_d     = grant_q + {15'd0, aux_ack_d};
      // a forced aux issue steals the video slot offered in the same cycle
      drop_d      = (issue_aux && bus.vid_req && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         wait_q      <= '0;
         tag_q       <= '0;
         map_row_q   <= '0;
         map_col_q   <= '0;
         vid_pixel_q <= '0;
         vid_valid_q <= 1'b0;
         aux_pixel_q <= '0;
         aux_ack_q   <= 1'b0;
         drop_q      <= '0;
         grant_q     <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         tag_q       <= tag_d;
         map_row_q   <= map_row_d;
         map_col_q   <= map_col_d;
         vid_pixel_q <= vid_pixel_d;
         vid_valid_q <= vid_valid_d;
         aux_pixel_q <= aux_pixel_d;
         aux_ack_q   <= aux_ack_d;
         drop_q      <= drop_d;
         grant_q     <= grant_d;
      end
   end
   assign bus.map_row         = map_row_q;
   assign bus.map_col         = map_col_q;
   assign bus.vid_pixel       = vid_pixel_q;
   assign bus.vid_pixel_valid = vid_valid_q;
   assign bus.aux_pixel       = aux_pixel_q;
   assign bus.aux_ack         = aux_ack_q;
   assign bus.vid_drop_cnt    = drop_q;
   assign bus.aux_grant_cnt   = grant_q;
endmodule

// File: tb/tb_map_port_arbiter.sv
// tb_map_port_arbiter: two arbiters (MAP_LAT 1/64-cycle guard, MAP_LAT 4/5-cycle guard) under shared
// video traffic, each with its own aux requester and map, against a cycle-scheduled reference model.
module tb_map_port_arbiter;
   localparam int L0 = 1, L1 = 4, S0 = 64, S1 = 5;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   map_port_arbiter_if b0 ();
   map_port_arbiter_if b1 ();
   map_port_arbiter #(.MAP_LAT(L0), .STARVE_LIMIT(S0)) u0 (.clk(clk), .reset(rst), .bus(b0));
   map_port_arbiter #(.MAP_LAT(L1), .STARVE_LIMIT(S1)) u1 (.clk(clk), .reset(rst), .bus(b1));
   logic       vr = 1'b0;
   logic [9:0] vrow = '0, vcol = '0;
   logic       ar [2] = '{1'b0, 1'b0};
   logic [9:0] arow [2] = '{10'd0, 10'd0};
   logic [9:0] acol [2] = '{10'd0, 10'd0};
   logic [1:0] mp [2] = '{2'd0, 2'd0};
   assign b0.vid_req = vr;  assign b0.vid_row = vrow; assign b0.vid_col = vcol;
   assign b1.vid_req = vr;  assign b1.vid_row = vrow; assign b1.vid_col = vcol;
   assign b0.aux_req = ar[0]; assign b0.aux_row = arow[0]; assign b0.aux_col = acol[0];
   assign b1.aux_req = ar[1]; assign b1.aux_row = arow[1]; assign b1.aux_col = acol[1];
   assign b0.map_pixel = mp[0];
   assign b1.map_pixel = mp[1];
   int checks = 0, failures = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [1:0] mapf(input logic [9:0] r, input logic [9:0] c);
      logic [9:0] x;
      x = r ^ (c >> 1) ^ (r >> 3);
      return x[1:0];
   endfunction
   // reference model: aux phase 0 idle, 1 pending, 2 in flight, 3 done; returns scheduled by cycle
   int         lat [2] = '{L0, L1};
   int         lim [2] = '{S0, S1};
   int         st [2], wt [2], cdrop [2], cgrant [2];
   bit         evv [2][16], eack [2][16];
   logic [1:0] evp [2][16], eap [2][16];
   bit         cvv [2], cack [2];
   logic [1:0] cvp [2], cap [2];
   logic [9:0] crow [2], ccol [2];
   logic [19:0] hist [2][16];
   logic       ovv [2], oack [2];
   logic [1:0] ovp [2], oap [2];
   logic [15:0] odrop [2], ogrant [2];
   logic [9:0] orow [2], ocol [2];
   task automatic step(input int u, input int k);
      int  s, e;
      bit  ia;
      s = (k + 1) % 16;
      if (rst) begin
         st[u] = 0; wt[u] = 0; cdrop[u] = 0; cgrant[u] = 0;
         cvv[u] = 0; cack[u] = 0; cvp[u] = 0; cap[u] = 0; crow[u] = 0; ccol[u] = 0;
         for (int i = 0; i < 16; i++) begin evv[u][i] = 0; eack[u][i] = 0; end
         return;
      end
      ia = 0;
      e = (k + lat[u] + 2) % 16;
      if (st[u] == 1) begin
         if (!ar[u]) st[u] = 0;
         else if (!vr || wt[u] == lim[u] - 1) begin ia = 1; st[u] = 2; wt[u] = 0; end
         else wt[u]++;
      end else if (st[u] == 0) begin
         if (ar[u]) begin st[u] = 1; wt[u] = 0; end
      end else if (st[u] == 3) st[u] = 0;
      if (ia) begin
         crow[u] = arow[u]; ccol[u] = acol[u];
         eack[u][e] = 1; eap[u][e] = mapf(arow[u], acol[u]);
         if (vr && cdrop[u] < 65535) cdrop[u]++;
      end else if (vr) begin
         crow[u] = vrow; ccol[u] = vcol;
         evv[u][e] = 1; evp[u][e] = mapf(vrow, vcol);
      end
      cvv[u] = evv[u][s];
      if (cvv[u]) cvp[u] = evp[u][s];
      cack[u] = eack[u][s];
      if (cack[u]) begin
         cap[u] = eap[u][s];
         cgrant[u] = (cgrant[u] + 1) % 65536;
         st[u] = 3;
      end
      evv[u][s] = 0; eack[u][s] = 0;
   endtask
   initial begin
      bit armed, want, fixed_addr, early_drop, dropped;
      armed = 0;
      for (int k = 0; k < 1140; k++) begin
         @(posedge clk); #1;
         ovv[0] = b0.vid_pixel_valid; ovv[1] = b1.vid_pixel_valid;
         ovp[0] = b0.vid_pixel;       ovp[1] = b1.vid_pixel;
         oack[0] = b0.aux_ack;        oack[1] = b1.aux_ack;
         oap[0] = b0.aux_pixel;       oap[1] = b1.aux_pixel;
         odrop[0] = b0.vid_drop_cnt;  odrop[1] = b1.vid_drop_cnt;
         ogrant[0] = b0.aux_grant_cnt; ogrant[1] = b1.aux_grant_cnt;
         orow[0] = b0.map_row; orow[1] = b1.map_row;
         ocol[0] = b0.map_col; ocol[1] = b1.map_col;
         for (int u = 0; u < 2; u++) begin
            hist[u][k % 16] = {orow[u], ocol[u]};
            if (armed) begin
               check($sformatf("u%0d vid_valid k=%0d", u, k), 32'(ovv[u]), 32'(cvv[u]));
               check($sformatf("u%0d vid_pixel k=%0d", u, k), 32'(ovp[u]), 32'(cvp[u]));
               check($sformatf("u%0d aux_ack k=%0d", u, k), 32'(oack[u]), 32'(cack[u]));
               check($sformatf("u%0d aux_pixel k=%0d", u, k), 32'(oap[u]), 32'(cap[u]));
               check($sformatf("u%0d drop_cnt k=%0d", u, k), 32'(odrop[u]), 32'(cdrop[u]));
               check($sformatf("u%0d grant_cnt k=%0d", u, k), 32'(ogrant[u]), 32'(cgrant[u]));
               check($sformatf("u%0d map_row k=%0d", u, k), 32'(orow[u]), 32'(crow[u]));
               check($sformatf("u%0d map_col k=%0d", u, k), 32'(ocol[u]), 32'(ccol[u]));
            end
         end
         rst = k < 3 || k == 312 || k == 326 || (k >= 340 && $urandom_range(0, 299) == 0);
         want = k >= 28;
         fixed_addr = k >= 28 && k < 48;
         early_drop = k >= 340;
         if (k < 28) begin vr = k >= 3; vrow = '0; vcol = 10'((k - 3) % 16); end
         else if (k < 48) vr = 1'b0;
         else if (k < 248) begin vr = 1'b1; vrow = 10'($urandom); vcol = 10'($urandom); end
         else if (k < 308) begin vr = k[0]; vrow = 10'($urandom); vcol = 10'($urandom); end
         else if (k < 340) vr = 1'b0;
         else begin vr = 1'($urandom); vrow = 10'($urandom); vcol = 10'($urandom); end
         for (int u = 0; u < 2; u++) begin
            dropped = 0;
            if (ar[u] && (oack[u] || (early_drop && $urandom_range(0, 49) == 0))) begin
               ar[u] = 1'b0; dropped = 1;
            end
            if (!ar[u] && !dropped && want && $urandom_range(0, 1) == 1) begin
               ar[u] = 1'b1;
               arow[u] = fixed_addr ? 10'd5 : 10'($urandom);
               acol[u] = fixed_addr ? 10'd7 : 10'($urandom);
            end
            mp[u] = mapf(hist[u][(k + 16 - lat[u]) % 16][19:10], hist[u][(k + 16 - lat[u]) % 16][9:0]);
            step(u, k);
         end
         armed = 1;
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
